// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small first-word-fall-through receive FIFO.
// RXD is double-flopped, each bit is sampled at mid-bit by a down-counter,
// and good bytes are pushed into the FIFO. The FIFO head is presented
// combinationally on o_data.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on the synchronised RXD
// START | counting to mid start bit; a high sample there is a glitch
// DATA  | sampling 8 data bits, LSB first, one every CLKS_PER_BIT
// STOP  | sampling the stop bit; high pushes the byte, low is a framing error
// BREAK | line held low after a framing error; wait for it to return high

module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 615000,
    parameter int BAUD_RATE   = 56000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       i_pop,
    input  logic       i_clr_err,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int C  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int H  = C / 2;
    localparam int CW = $clog2(C);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(C - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    generate
        if (C < 4) begin : g_bad_baud
            $error("uart_rx_fifo: CLKS_PER_BIT must be at least 4");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_rx_fifo: FIFO_DEPTH must be a power of two and >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_req;
    logic          frame_set;

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Next-state logic; push_req and frame_set pulse on the stop-bit sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    state_d   = DATA;
                    cnt_d     = CNT_FULL;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    push_req = 1'b1;
                    state_d  = IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_d   = BREAK;
                end
            end
            BREAK: begin
                // A line held low must go high before a new start is accepted.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic        empty, full;
    logic        do_pop, do_push, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = i_pop && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && full && !do_pop;

    // FIFO pointers and storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Pointer advance and tail write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    // Error flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Clear first, then set, so a new error in the clear cycle is kept.
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (frame_set) begin
            frame_err_d = 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    assign o_data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign o_valid     = !empty;
    assign o_busy      = (state_q != IDLE);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (10 clk per bit).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.

module tb_uart_rx_fifo;

    localparam int C = 10;

    logic       clk;
    logic       resetn;
    logic       rxd;
    logic       i_pop;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo dut (
        .clk         (clk),
        .resetn      (resetn),
        .rxd         (rxd),
        .i_pop       (i_pop),
        .i_clr_err   (i_clr_err),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; rxd is left at the stop level.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (C) tick();
        end
        rxd = stop;
        repeat (C) tick();
    endtask

    task automatic send_ok(input logic [7:0] data);
        send_frame(data, 1'b1);
        rxd = 1'b1;
        repeat (2) tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, o_data}, {24'd0, exp});
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
    endtask

    task automatic clr_err();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
    endtask

    int  lat;
    logic saw_busy;

    initial begin
        resetn    = 1'b0;
        rxd       = 1'b1;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {19'd0, o_data, o_valid, o_busy, o_frame_err, o_overrun}, 32'd0);
        resetn = 1'b1;
        repeat (3) tick();

        // 1. single byte, latency from falling edge
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 200; n++) begin
                    tick();
                    if (o_valid && lat < 0) lat = n;
                end
            end
        join_any
        disable fork;
        rxd = 1'b1;
        repeat (2) tick();
        check("t1_latency", lat, 32'd98);
        check("t1_flags", {30'd0, o_frame_err, o_overrun}, 32'd0);
        pop_expect("t1_pop", 8'hA5);
        check("t1_empty_valid", {31'd0, o_valid}, 32'd0);
        check("t1_empty_data", {24'd0, o_data}, 32'd0);

        // 2. glitch on rxd is rejected
        saw_busy = 1'b0;
        rxd = 1'b0;
        repeat (3) begin
            tick();
            saw_busy |= o_busy;
        end
        rxd = 1'b1;
        repeat (20) begin
            tick();
            saw_busy |= o_busy;
        end
        check("t2_busy_pulsed", {31'd0, saw_busy}, 32'd1);
        check("t2_idle_after", {28'd0, o_busy, o_valid, o_frame_err, o_overrun}, 32'd0);

        // 3. framing error, line held low, then a good byte
        send_frame(8'h3C, 1'b0);
        check("t3_frame_err", {31'd0, o_frame_err}, 32'd1);
        check("t3_no_push", {31'd0, o_valid}, 32'd0);
        repeat (40) tick();
        check("t3_break_no_retrigger", {31'd0, o_valid}, 32'd0);
        rxd = 1'b1;
        repeat (5) tick();
        send_ok(8'h55);
        pop_expect("t3_pop", 8'h55);
        check("t3_only_one", {31'd0, o_valid}, 32'd0);
        check("t3_err_held", {31'd0, o_frame_err}, 32'd1);
        clr_err();
        check("t3_err_cleared", {31'd0, o_frame_err}, 32'd0);

        // 4. overrun after five bytes with no pops
        for (int b = 1; b <= 4; b++) send_ok(8'(b));
        check("t4_no_overrun_at_4", {31'd0, o_overrun}, 32'd0);
        send_ok(8'h05);
        check("t4_overrun", {31'd0, o_overrun}, 32'd1);
        pop_expect("t4_pop1", 8'h01);
        pop_expect("t4_pop2", 8'h02);
        pop_expect("t4_pop3", 8'h03);
        pop_expect("t4_pop4", 8'h04);
        check("t4_drained", {31'd0, o_valid}, 32'd0);
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        check("t4_pop_empty", {31'd0, o_valid}, 32'd0);
        clr_err();
        check("t4_overrun_cleared", {31'd0, o_overrun}, 32'd0);

        // 5. push into a full FIFO with a pop in the same cycle
        for (int b = 1; b <= 4; b++) send_ok(8'(b));
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (97) tick();
                i_pop = 1'b1;
                tick();
                i_pop = 1'b0;
            end
        join
        rxd = 1'b1;
        repeat (2) tick();
        check("t5_no_overrun", {31'd0, o_overrun}, 32'd0);
        pop_expect("t5_pop1", 8'h02);
        pop_expect("t5_pop2", 8'h03);
        pop_expect("t5_pop3", 8'h04);
        pop_expect("t5_pop4", 8'h77);
        check("t5_drained", {31'd0, o_valid}, 32'd0);

        // 6. reset during bit 3 of 0xC3, with a byte already queued
        send_ok(8'h11);
        check("t6_pre_valid", {31'd0, o_valid}, 32'd1);
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 3; i++) begin
            rxd = (i < 2) ? 1'b1 : 1'b0;
            repeat (C) tick();
        end
        rxd = 1'b0;
        repeat (5) tick();
        check("t6_busy_mid_frame", {31'd0, o_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_reset_async", {19'd0, o_data, o_valid, o_busy, o_frame_err, o_overrun}, 32'd0);
        repeat (3) tick();
        rxd = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (5) tick();
        check("t6_idle_after_reset", {28'd0, o_busy, o_valid, o_frame_err, o_overrun}, 32'd0);
        send_ok(8'h5A);
        pop_expect("t6_pop", 8'h5A);
        check("t6_only_one", {31'd0, o_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
